gon_multicast_v2: RTL and testbench
===================================

// Module: gon_multicast_v2
// PURPOSE
//   Global on-chip multicast network, next generation: delivers one word from the global
//   buffer to any subset of the NUM_OF_ROWS x NUM_OF_COLS PE array in one transaction.
//   Destinations are PEs whose scan-loaded row ID and column ID match the transaction
//   tags. An all-ones tag is a wildcard.
//   Adds registered delivery, per-PE partial delivery, a no-match drop path and a drop counter.
// PARAMETERS
//   DATA_WIDTH      64  payload width
//   ROW_TAG_WIDTH   4   row tag / row ID width
//   COL_TAG_WIDTH   4   column tag / column ID width
//   NUM_OF_ROWS     12  PE rows
//   NUM_OF_COLS     14  PE columns
//   WILDCARD_EN     1   1: all-ones tag matches every ID; 0: exact match only
//   CNT_WIDTH       16  width of the no-match drop counter
// PORTS
//   clk          in   1                  clock
//   reset        in   1                  asynchronous, active-low reset
//   scan_en_id   in   1                  ID scan-chain shift enable
//   scan_in_id   in   1                  ID scan-chain serial in
//   scan_out_id  out  1                  ID scan-chain serial out
//   in_valid     in   1                  transaction valid from GLB
//   in_ready     out  1                  network accepts a transaction
//   in_data      in   DATA_WIDTH         payload
//   in_row_tag   in   ROW_TAG_WIDTH      destination row tag
//   in_col_tag   in   COL_TAG_WIDTH      destination column tag
//   pe_ready     in   [ROWS][COLS]       PE can accept a word this cycle
//   pe_enable    out  [ROWS][COLS]       word is written into the PE this cycle
//   pe_data      out  DATA_WIDTH         payload, shared by all PEs
//   busy         out  1                  state == DELIVER
//   nomatch_cnt  out  CNT_WIDTH          count of dropped (zero-target) transactions
// BEHAVIOUR
//   Reset (reset=0): state=IDLE; pending mask=0; pe_data=0; all IDs=0; nomatch_cnt=0.
//     Consequences: pe_enable=0, busy=0, scan_out_id=0.
//   ID chain: one shift register, L = ROWS*ROW_TAG_WIDTH + ROWS*COLS*COL_TAG_WIDTH bits.
//     Segment order from scan_in_id side: row r ID (r=0 first), then col IDs (r,0..COLS-1).
//     Segments are interleaved per row: row0, cols(0,*), row1, cols(1,*), ...
//     Each shift moves every bit one position toward scan_out_id (the last bit of row ROWS-1).
//     The chain shifts on every clk edge with scan_en_id=1, in any state.
//   Match rule: match[r][c] = rowhit[r] & colhit[r][c].
//     rowhit[r] = (in_row_tag == row_id[r]) | (WILDCARD_EN & in_row_tag all-ones).
//     colhit is the same rule, applied to the column tag.
//   in_ready = (state==IDLE) & ~scan_en_id. A handshake is in_valid & in_ready at a clk edge.
//   FSM:
//     IDLE -> handshake with match != 0:
//       pe_data <= in_data; pending <= match; state <= DELIVER.
//     IDLE -> handshake with match == 0:
//       transaction dropped; nomatch_cnt += 1, saturating at all-ones; stay IDLE.
//     DELIVER:
//       pe_enable[r][c] = pending[r][c] & pe_ready[r][c] (combinational).
//       At the edge, pending &= ~pe_enable. PEs are delivered independently, so a slow PE
//       does not stall delivery to the others.
//     DELIVER -> IDLE at the edge where (pending & ~pe_enable) == 0.
//       in_ready rises in the following cycle.
//   Latency: handshake at edge N. The earliest pe_enable is in cycle N+1. Back-to-back
//     single-cycle deliveries sustain one transaction every 2 cycles.
//   pe_data is held stable for the whole of DELIVER. pe_enable is never asserted in IDLE.
//   Matching uses the IDs at the handshake edge. Scanning during DELIVER does not change
//     pending, but it blocks new handshakes.
//   A pe_ready that deasserts mid-DELIVER only delays that PE; no other PE is affected.
//   Reset mid-DELIVER: the transaction is abandoned, the pending mask is cleared and the
//     IDs return to 0. The GLB must reissue the transaction.
// TESTING
//   1. Exact multicast, all PEs ready.
//      Scan in row IDs = r and col IDs = c; send row_tag=3, col_tag=5.
//      -> pe_enable[3][5] only, in cycle N+1. in_ready returns at N+2.
//   2. Wildcard broadcast, one PE stalled.
//      row_tag=4'hF, col_tag=4'hF, all IDs 0; pe_ready[0][0]=0 for 3 cycles.
//      -> all other 167 PEs enabled in cycle N+1. [0][0] is enabled in cycle N+4. busy=1 for 4 cycles.
//   3. No match.
//      IDs = 0; send row_tag=2.
//      -> in_ready stays 1, pe_enable stays 0, nomatch_cnt 0->1. With CNT_WIDTH=2: 3 stays 3.
//   4. Scan round trip.
//      Shift in a 720-bit pattern, then 720 more bits.
//      -> scan_out_id reproduces the first pattern. in_ready=0 while scan_en_id=1.
//   5. Reset mid-DELIVER, with pe_ready=0 everywhere.
//      -> pe_enable=0, busy=0, nomatch_cnt=0 immediately. IDs read back 0 over the chain.
//   6. WILDCARD_EN=0, row_tag=4'hF, row_id[1]=4'hF.
//      -> only row 1 matches.

Source files
------------

// File: rtl/gon_multicast_v2_if.sv
// Transaction and PE-delivery bundle for the global multicast network.
// The master side is the GLB/PE array; the slave side is the network.
interface gon_multicast_v2_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int NUM_OF_ROWS   = 12,
  parameter int NUM_OF_COLS   = 14
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic [DATA_WIDTH-1:0]                   in_data;
  logic [ROW_TAG_WIDTH-1:0]                in_row_tag;
  logic [COL_TAG_WIDTH-1:0]                in_col_tag;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] pe_ready;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] pe_enable;
  logic [DATA_WIDTH-1:0]                   pe_data;

  modport master (
    output in_valid, in_data, in_row_tag, in_col_tag, pe_ready,
    input  in_ready, pe_enable, pe_data
  );

  modport slave (
    input  in_valid, in_data, in_row_tag, in_col_tag, pe_ready,
    output in_ready, pe_enable, pe_data
  );
endinterface

// File: rtl/gon_multicast_v2.sv
// Global multicast network: one GLB word delivered to every PE whose scan-loaded
// row/column IDs match the transaction tags, with per-PE partial delivery and drop counting.
module gon_multicast_v2 #(
  parameter int DATA_WIDTH    = 64,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4,
  parameter int NUM_OF_ROWS   = 12,
  parameter int NUM_OF_COLS   = 14,
  parameter int WILDCARD_EN   = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scan_en_id,
  input  logic                 scan_in_id,
  output logic                 scan_out_id,
  gon_multicast_v2_if.slave    bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] nomatch_cnt
);

  localparam int unsigned SEG = ROW_TAG_WIDTH + NUM_OF_COLS * COL_TAG_WIDTH;
  localparam int unsigned L   = NUM_OF_ROWS * SEG;

  typedef enum logic {IDLE, DELIVER} state_t;

  state_t                                  state_q, state_d;
  logic [L-1:0]                            chain_q, chain_d;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] pending_q, pending_d;
  logic [DATA_WIDTH-1:0]                   data_q, data_d;
  logic [CNT_WIDTH-1:0]                    cnt_q, cnt_d;

  logic                                    row_wild, col_wild;
  logic [NUM_OF_ROWS-1:0]                  rowhit;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] colhit;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] match;
  logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0] pe_en;

  assign row_wild = (WILDCARD_EN != 0) && (&bus.in_row_tag);
  assign col_wild = (WILDCARD_EN != 0) && (&bus.in_col_tag);

  // Chain layout per row, from the scan_in side: row ID, then column IDs 0..COLS-1.
  always_comb begin
    rowhit = '0;
    colhit = '0;
    for (int unsigned r = 0; r < NUM_OF_ROWS; r++) begin
      rowhit[r] = row_wild || (bus.in_row_tag == chain_q[r*SEG +: ROW_TAG_WIDTH]);
      for (int unsigned c = 0; c < NUM_OF_COLS; c++) begin
        colhit[r][c] = col_wild ||
          (bus.in_col_tag == chain_q[r*SEG + ROW_TAG_WIDTH + c*COL_TAG_WIDTH +: COL_TAG_WIDTH]);
      end
    end
  end

  always_comb begin
    match = '0;
    for (int unsigned r = 0; r < NUM_OF_ROWS; r++) begin
      for (int unsigned c = 0; c < NUM_OF_COLS; c++) begin
        match[r][c] = rowhit[r] & colhit[r][c];
      end
    end
  end

  assign chain_d      = scan_en_id ? {chain_q[L-2:0], scan_in_id} : chain_q;
  assign scan_out_id  = chain_q[L-1];
  assign bus.in_ready = (state_q == IDLE) && !scan_en_id;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    pe_en     = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          if (|match) begin
            pending_d = match;
            data_d    = bus.in_data;
            state_d   = DELIVER;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DELIVER: begin
        // Each PE retires independently; leave once nothing remains pending.
        pe_en     = pending_q & bus.pe_ready;
        pending_d = pending_q & ~pe_en;
        if (pending_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      chain_q   <= '0;
      pending_q <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      chain_q   <= chain_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.pe_enable = pe_en;
  assign bus.pe_data   = data_q;
  assign busy          = (state_q == DELIVER);
  assign nomatch_cnt   = cnt_q;

endmodule

// File: tb/tb_gon_multicast_v2.sv
// Randomized bench for gon_multicast_v2: a wildcard/16-bit-counter instance and an
// exact-match/2-bit-counter instance share stimulus, each checked against its own model.
module tb_gon_multicast_v2;
  localparam int DW  = 64;
  localparam int RW  = 4;
  localparam int CW  = 4;
  localparam int NR  = 12;
  localparam int NC  = 14;
  localparam int SEG = RW + NC * CW;
  localparam int L   = NR * SEG;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                   scan_en = 1'b0;
  logic                   scan_in = 1'b0;
  logic                   v = 1'b0;
  logic [DW-1:0]          d = '0;
  logic [RW-1:0]          rt = '0;
  logic [CW-1:0]          ct = '0;
  logic [NR-1:0][NC-1:0]  rdy = '0;

  logic        scan_out0, scan_out1, busy0, busy1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  gon_multicast_v2_if #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                        .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus0 ();
  gon_multicast_v2_if #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                        .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC)) bus1 ();

  assign bus0.in_valid = v;   assign bus1.in_valid = v;
  assign bus0.in_data  = d;   assign bus1.in_data  = d;
  assign bus0.in_row_tag = rt; assign bus1.in_row_tag = rt;
  assign bus0.in_col_tag = ct; assign bus1.in_col_tag = ct;
  assign bus0.pe_ready = rdy; assign bus1.pe_ready = rdy;

  gon_multicast_v2 #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                     .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .WILDCARD_EN(1), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .scan_en_id(scan_en), .scan_in_id(scan_in),
    .scan_out_id(scan_out0), .bus(bus0), .busy(busy0), .nomatch_cnt(cnt0));

  gon_multicast_v2 #(.DATA_WIDTH(DW), .ROW_TAG_WIDTH(RW), .COL_TAG_WIDTH(CW),
                     .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .WILDCARD_EN(0), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .scan_en_id(scan_en), .scan_in_id(scan_in),
    .scan_out_id(scan_out1), .bus(bus1), .busy(busy1), .nomatch_cnt(cnt1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: chain as a bit array (index 0 nearest scan_in), per-instance delivery state.
  bit                    sc[L];
  bit                    m_busy[2];
  logic [NR-1:0][NC-1:0] m_pend[2];
  logic [DW-1:0]         m_data[2];
  int unsigned           m_cnt[2];

  function automatic int unsigned cmax(int k);
    return (k == 0) ? 65535 : 3;
  endfunction

  function automatic int id_at(int off, int w);
    int val = 0;
    for (int b = 0; b < w; b++) if (sc[off + b]) val |= (1 << b);
    return val;
  endfunction

  function automatic logic [NR-1:0][NC-1:0] model_match(int k);
    logic [NR-1:0][NC-1:0] m = '0;
    bit wild = (k == 0);
    for (int r = 0; r < NR; r++) begin
      bit rh = (int'(rt) == id_at(r * SEG, RW)) || (wild && rt == 4'hF);
      for (int c = 0; c < NC; c++) begin
        bit ch = (int'(ct) == id_at(r * SEG + RW + c * CW, CW)) || (wild && ct == 4'hF);
        m[r][c] = rh && ch;
      end
    end
    return m;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_pend[k] = '0; m_data[k] = '0; m_cnt[k] = 0;
    end
    for (int i = 0; i < L; i++) sc[i] = 0;
  endtask

  task automatic check_outputs(input string ph);
    for (int k = 0; k < 2; k++) begin
      logic [NR-1:0][NC-1:0] en = m_busy[k] ? (m_pend[k] & rdy) : '0;
      chk($sformatf("%s_d%0d_in_ready", ph, k), k ? bus1.in_ready : bus0.in_ready,
          !m_busy[k] && !scan_en);
      chk($sformatf("%s_d%0d_pe_enable", ph, k), k ? bus1.pe_enable : bus0.pe_enable, en);
      chk($sformatf("%s_d%0d_busy", ph, k), k ? busy1 : busy0, m_busy[k]);
      chk($sformatf("%s_d%0d_pe_data", ph, k), k ? bus1.pe_data : bus0.pe_data, m_data[k]);
      chk($sformatf("%s_d%0d_cnt", ph, k), k ? 16'(cnt1) : cnt0, m_cnt[k]);
      chk($sformatf("%s_d%0d_scan_out", ph, k), k ? scan_out1 : scan_out0, sc[L-1]);
    end
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic step(input string ph);
    logic [NR-1:0][NC-1:0] mt[2];
    @(negedge clk);
    check_outputs(ph);
    for (int k = 0; k < 2; k++) mt[k] = model_match(k);
    if (!reset) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        if (m_busy[k]) begin
          m_pend[k] = m_pend[k] & ~(m_pend[k] & rdy);
          if (m_pend[k] == '0) m_busy[k] = 0;
        end else if (v && !scan_en) begin
          if (mt[k] != '0) begin
            m_busy[k] = 1; m_pend[k] = mt[k]; m_data[k] = d;
          end else if (m_cnt[k] < cmax(k)) m_cnt[k]++;
        end
      end
      if (scan_en) begin
        for (int i = L - 1; i > 0; i--) sc[i] = sc[i-1];
        sc[0] = scan_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int rid[NR];
  int cid[NR][NC];

  task automatic load_ids(input string ph);
    bit tgt[L];
    for (int r = 0; r < NR; r++) begin
      for (int b = 0; b < RW; b++) tgt[r*SEG + b] = rid[r][b];
      for (int c = 0; c < NC; c++)
        for (int b = 0; b < CW; b++) tgt[r*SEG + RW + c*CW + b] = cid[r][c][b];
    end
    scan_en = 1;
    for (int i = L - 1; i >= 0; i--) begin
      scan_in = tgt[i];
      step(ph);
    end
    scan_en = 0;
    scan_in = 0;
  endtask

  task automatic set_ids(input int mode);
    for (int r = 0; r < NR; r++) begin
      rid[r] = (mode == 1) ? r : (mode == 2) ? ($urandom_range(0, 4) == 4 ? 15 : $urandom_range(0, 3)) : 0;
      for (int c = 0; c < NC; c++)
        cid[r][c] = (mode == 1) ? c : (mode == 2) ? ($urandom_range(0, 4) == 4 ? 15 : $urandom_range(0, 3)) : 0;
    end
  endtask

  task automatic send(input string ph, input logic [RW-1:0] r, input logic [CW-1:0] c);
    rt = r; ct = c; d = {$urandom, $urandom}; v = 1;
    step(ph);
    v = 0;
  endtask

  bit pat[L];

  initial begin
    model_reset();
    step("rst"); step("rst");
    reset = 1;
    scan_en = 1;
    for (int i = 0; i < L; i++) step("rst_ids");
    scan_en = 0;

    // Exact multicast to PE (3,5)
    set_ids(1); load_ids("ld1");
    rdy = '1;
    send("exact", 4'd3, 4'd5);
    repeat (3) step("exact");

    // Wildcard broadcast with PE (0,0) stalled three cycles
    set_ids(0); load_ids("ld0");
    rdy = '1; rdy[0][0] = 0;
    send("bcast", 4'hF, 4'hF);
    repeat (3) step("bcast");
    rdy[0][0] = 1;
    repeat (3) step("bcast");

    // No-match drops, saturating the narrow counter
    rt = 4'd2; ct = 4'd0; v = 1;
    repeat (5) step("nomatch");
    v = 0;

    // Exact-match instance: only row 1 carries the all-ones row ID
    set_ids(0); rid[1] = 15; load_ids("ld6");
    send("exact_f", 4'hF, 4'd0);
    repeat (3) step("exact_f");

    // Scan round trip while a transaction is offered
    v = 1; rt = 4'hF; ct = 4'hF;
    scan_en = 1;
    for (int i = 0; i < L; i++) begin
      pat[i] = 1'($urandom); scan_in = pat[i]; step("scan1");
    end
    for (int i = 0; i < L; i++) begin
      chk("scan_roundtrip", scan_out0, pat[i]);
      scan_in = 1'($urandom); step("scan2");
    end
    scan_en = 0; v = 0;

    // Random traffic over random IDs
    set_ids(2); load_ids("ldr");
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 2) != 0);
      rt = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      ct = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++) rdy[r][c] = ($urandom_range(0, 3) != 0);
      scan_en = ($urandom_range(0, 19) == 0);
      scan_in = 1'($urandom);
      step("rand");
    end
    scan_en = 0; v = 0;

    // Asynchronous reset in the middle of a stalled delivery
    set_ids(0); load_ids("ld5");
    rdy = '0;
    send("rst_mid", 4'hF, 4'hF);
    rt = 4'd9; v = 1; step("rst_mid"); v = 0; step("rst_mid");
    #2 reset = 0;
    #1 model_reset();
    chk("rst_mid_pe_enable", bus0.pe_enable, '0);
    chk("rst_mid_busy", busy0, 1'b0);
    chk("rst_mid_cnt", cnt0, 16'd0);
    chk("rst_mid_cnt1", cnt1, 2'd0);
    step("rst_low");
    reset = 1;
    scan_en = 1; scan_in = 0;
    for (int i = 0; i < L; i++) step("rst_ids2");
    scan_en = 0;
    step("end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
